// File: rtl/bfly_seq_pkg.sv
// Shared types and sizing constants for the 8-point
// sequential butterfly transform.
package bfly_seq_pkg;

  localparam int NPT    = 8;
  localparam int NSTAGE = 3;
  localparam int NBFLY  = 4;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    CALC,
    DRAIN
  } state_t;

endpackage

// File: rtl/bfly_seq_butterfly1.sv
// Combinational radix-2 butterfly: sum and scaled difference,
// both wrapping in two's complement at DW bits.
module butterfly1 #(
  parameter int DW = 15
) (
  input  logic signed [DW-1:0] ai,
  input  logic signed [DW-1:0] bi,
  output logic signed [DW-1:0] ao,
  output logic signed [DW-1:0] bo
);

  logic signed [DW-1:0] w_d;

  assign ao  = ai + bi;
  assign w_d = ai - bi;
  assign bo  = {w_d[DW-3:0], 2'b00};

endmodule

// File: rtl/bfly_seq.sv
// Sequential 8-point in-place radix-2 transform:
// load 8 samples, 12 butterfly cycles, drain 8 samples.
module bfly_seq
  import bfly_seq_pkg::*;
#(
  parameter int DW = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [DW-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [DW-1:0] out_data,
  output logic                 busy,
  output logic                 done
);

  state_t               r_state;
  state_t               w_next;
  logic [2:0]           r_cnt;
  logic [1:0]           r_stage;
  logic [1:0]           r_k;
  logic                 r_done;
  logic signed [DW-1:0] r_a [NPT];

  logic                 w_in_acc;
  logic                 w_out_acc;
  logic                 w_calc_last;
  logic [2:0]           w_i;
  logic [2:0]           w_j;
  logic [2:0]           w_span;
  logic signed [DW-1:0] w_ao;
  logic signed [DW-1:0] w_bo;

  assign w_in_acc    = in_valid & in_ready;
  assign w_out_acc   = out_valid & out_ready;
  assign w_calc_last = (r_stage == 2'(NSTAGE - 1))
                     && (r_k == 2'(NBFLY - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_in_acc) w_next = LOAD;
      LOAD:    if (w_in_acc && r_cnt == 3'(NPT - 1))
                 w_next = CALC;
      CALC:    if (w_calc_last) w_next = DRAIN;
      DRAIN:   if (w_out_acc && r_cnt == 3'(NPT - 1))
                 w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == IDLE) || (r_state == LOAD);
    out_valid = (r_state == DRAIN);
    out_data  = (r_state == DRAIN) ? r_a[r_cnt] : '0;
    busy      = (r_state != IDLE);
    done      = r_done;
  end

  // i = (k/h)*2h + k%h, with h = 4 >> stage
  always_comb begin
    w_span = 3'd4 >> r_stage;
    unique case (1'b1)
      (r_stage == 2'd0): w_i = {1'b0, r_k};
      (r_stage == 2'd1): w_i = {r_k[1], 1'b0, r_k[0]};
      default:           w_i = {r_k, 1'b0};
    endcase
    w_j = w_i + w_span;
  end

  butterfly1 #(.DW(DW)) u_bfly (
    .ai (r_a[w_i]),
    .bi (r_a[w_j]),
    .ao (w_ao),
    .bo (w_bo)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= '0;
      r_stage <= '0;
      r_k     <= '0;
      r_done  <= 1'b0;
      for (int n = 0; n < NPT; n++) r_a[n] <= '0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE, LOAD: begin
          if (w_in_acc) begin
            r_a[r_cnt] <= in_data;
            r_cnt      <= r_cnt + 3'd1;
          end
        end
        CALC: begin
          r_a[w_i] <= w_ao;
          r_a[w_j] <= w_bo;
          r_k      <= r_k + 2'd1;
          if (r_k == 2'(NBFLY - 1))
            r_stage <= w_calc_last ? 2'd0 : r_stage + 2'd1;
        end
        DRAIN: begin
          if (w_out_acc) begin
            r_cnt <= r_cnt + 3'd1;
            if (r_cnt == 3'(NPT - 1)) r_done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
